llr_interleaver: RTL

//  Ping-pong frame buffer between turbo SISO stages. Takes the SISO's 8-bit

---
 rtl/llr_interleaver.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/llr_interleaver.sv
// llr_interleaver: ping-pong LLR frame buffer between turbo SISO stages.
// Writes a frame of K LLRs in natural order into one bank while the other
// bank is replayed in QPP-permuted (mode 0) or inverse-permuted (mode 1)
// order. QPP addresses are generated incrementally, without a multiplier.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_start, i_mode           frame start marker and mode (sampled with i_start)
//   i_valid, i_data, o_ready  write-side stream handshake
//   o_valid, o_data, o_last   read-side stream, o_last on the K-th LLR
//   i_ready                   downstream accept
module llr_interleaver #(
   parameter int unsigned K  = 40,
   parameter int unsigned W  = 8,
   parameter int unsigned F1 = 3,
   parameter int unsigned F2 = 10
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic         i_mode,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_ready,
   output logic         o_valid,
   output logic [W-1:0] o_data,
   output logic         o_last,
   input  logic         i_ready
);

   localparam int unsigned AW = (K > 1) ? $clog2(K) : 1;
   localparam int unsigned MW = AW + 1;
   localparam logic [AW-1:0] G0   = AW'((F1 + F2) % K);
   localparam logic [AW-1:0] D    = AW'((2 * F2) % K);
   localparam logic [AW-1:0] LAST = AW'(K - 1);

   typedef enum logic {W_IDLE = 1'b0, W_FILL = 1'b1} wstate_t;
   typedef enum logic {R_IDLE = 1'b0, R_READ = 1'b1} rstate_t;

   // (a + b) mod K for operands already reduced mod K
   function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
      logic [AW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= MW'(K)) s = s - MW'(K);
      return s[AW-1:0];
   endfunction

   // Flat RAM index: bank 1 occupies entries K..2K-1
   function automatic logic [MW-1:0] idx(input logic bank, input logic [AW-1:0] addr);
      return bank ? (MW'(K) + MW'(addr)) : MW'(addr);
   endfunction

   wstate_t       wstate, wstate_n;
   logic [AW-1:0] wcnt, wcnt_n, wpi, wpi_n, wg, wg_n, w_addr;
   logic          wbank, wbank_n, w_hs, w_en, w_fin;
   logic [1:0]    mode, mode_n;

   rstate_t       rstate, rstate_n;
   logic [AW-1:0] rcnt, rcnt_n, rpi, rpi_n, rg, rg_n, r_addr, r_pi, r_g;
   logic          rbank, rbank_n, r_en, r_fin, pop, issue_ok;
   logic [1:0]    occ;

   logic [1:0]    full, full_n;

   logic [W-1:0]  mem [2*K];
   logic [W-1:0]  ram_q, skid_data;
   logic          p1_valid, p1_last, skid_valid, skid_last;

   // Write side: element 0 on i_start, then count/QPP step per handshake
   always_comb begin
      wstate_n = wstate;
      wcnt_n   = wcnt;
      wpi_n    = wpi;
      wg_n     = wg;
      wbank_n  = wbank;
      mode_n   = mode;
      w_en     = 1'b0;
      w_fin    = 1'b0;
      w_addr   = '0;
      w_hs     = i_valid & o_ready;
      if (w_hs && i_start) begin
         w_en           = 1'b1;
         wcnt_n         = AW'(1);
         wpi_n          = G0;
         wg_n           = mod_add(G0, D);
         mode_n[wbank]  = i_mode;
         wstate_n       = W_FILL;
      end else if (w_hs && (wstate == W_FILL)) begin
         w_en   = 1'b1;
         w_addr = mode[wbank] ? wpi : wcnt;
         wcnt_n = wcnt + AW'(1);
         wpi_n  = mod_add(wpi, wg);
         wg_n   = mod_add(wg, D);
         if (wcnt == LAST) begin
            w_fin    = 1'b1;
            wbank_n  = ~wbank;
            wstate_n = W_IDLE;
            wcnt_n   = '0;
            wpi_n    = '0;
            wg_n     = '0;
         end
      end
   end

   // Read side: issue a RAM read only when the output stage plus skid
   // register can absorb it even if downstream stalls next cycle.
   always_comb begin
      rstate_n = rstate;
      rcnt_n   = rcnt;
      rpi_n    = rpi;
      rg_n     = rg;
      rbank_n  = rbank;
      r_fin    = 1'b0;
      pop      = o_valid & i_ready;
      occ      = 2'(o_valid) + 2'(skid_valid) + 2'(p1_valid) - 2'(pop);
      issue_ok = (occ <= 2'd1);
      r_pi     = (rcnt == '0) ? '0 : rpi;
      r_g      = (rcnt == '0) ? G0 : rg;
      r_addr   = mode[rbank] ? rcnt : r_pi;
      r_en     = full[rbank] & issue_ok;
      if ((rstate == R_IDLE) && full[rbank]) rstate_n = R_READ;
      if (r_en) begin
         rcnt_n = rcnt + AW'(1);
         rpi_n  = mod_add(r_pi, r_g);
         rg_n   = mod_add(r_g, D);
         if (rcnt == LAST) begin
            r_fin    = 1'b1;
            rbank_n  = ~rbank;
            rcnt_n   = '0;
            rpi_n    = '0;
            rg_n     = '0;
            // Continue straight into the other bank if it is (becoming) full
            rstate_n = (full[~rbank] || (w_fin && (wbank != rbank))) ? R_READ : R_IDLE;
         end
      end
   end

   // Full flags: write-finish and read-finish always hit different banks
   always_comb begin
      full_n = full;
      if (w_fin) full_n[wbank] = 1'b1;
      if (r_fin) full_n[rbank] = 1'b0;
   end

   // Frame RAM, synchronous read
   always_ff @(posedge i_clk) begin
      if (w_en) mem[idx(wbank, w_addr)] <= i_data;
      if (r_en) ram_q <= mem[idx(rbank, r_addr)];
   end

   // State registers and two-entry output stage (output reg + skid)
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wstate     <= W_IDLE;
         wcnt       <= '0;
         wpi        <= '0;
         wg         <= '0;
         wbank      <= 1'b0;
         mode       <= '0;
         rstate     <= R_IDLE;
         rcnt       <= '0;
         rpi        <= '0;
         rg         <= '0;
         rbank      <= 1'b0;
         full       <= '0;
         o_ready    <= 1'b1;
         p1_valid   <= 1'b0;
         p1_last    <= 1'b0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_last  <= 1'b0;
         o_valid    <= 1'b0;
         o_data     <= '0;
         o_last     <= 1'b0;
      end else begin
         wstate   <= wstate_n;
         wcnt     <= wcnt_n;
         wpi      <= wpi_n;
         wg       <= wg_n;
         wbank    <= wbank_n;
         mode     <= mode_n;
         rstate   <= rstate_n;
         rcnt     <= rcnt_n;
         rpi      <= rpi_n;
         rg       <= rg_n;
         rbank    <= rbank_n;
         full     <= full_n;
         o_ready  <= ~full_n[wbank_n];
         p1_valid <= r_en;
         p1_last  <= r_en && (rcnt == LAST);
         if (pop) begin
            if (skid_valid) begin
               o_data     <= skid_data;
               o_last     <= skid_last;
               skid_valid <= p1_valid;
               skid_data  <= ram_q;
               skid_last  <= p1_last;
            end else begin
               o_valid <= p1_valid;
               o_last  <= p1_valid & p1_last;
               if (p1_valid) o_data <= ram_q;
            end
         end else if (!o_valid) begin
            if (p1_valid) begin
               o_valid <= 1'b1;
               o_data  <= ram_q;
               o_last  <= p1_last;
            end
         end else if (p1_valid) begin
            skid_valid <= 1'b1;
            skid_data  <= ram_q;
            skid_last  <= p1_last;
         end
      end
   end

endmodule
